// File: rtl/cmp_seq.sv
// cmp_seq: decode-stage branch-compare sequencer. Ports: clk, reset (sync, high),
// start/cmp_op/a/b request, flush; busy, stall, done pulse, result. Macro: CMP_EARLY_EXIT_EN.
module cmp_seq #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  cmp_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        result
);

  localparam int NCHUNK = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] KLAST = 6'(NCHUNK - 1);

  localparam logic [3:0] OP_BEQ   = 4'd0;
  localparam logic [3:0] OP_BGEZ  = 4'd1;
  localparam logic [3:0] OP_BGTZ  = 4'd2;
  localparam logic [3:0] OP_BLEZ  = 4'd3;
  localparam logic [3:0] OP_BLTZ  = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_NUMEQ = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    RESP
  } state_t;

  state_t      state;
  logic [31:0] a_lat;
  logic [31:0] b_lat;
  logic [5:0]  k;
  // two's complement running difference, -32..+32
  logic [6:0]  diff;
  logic [6:0]  diff_nxt;
  logic [31:0] sh;
  logic [BITS_PER_CYCLE-1:0] ca;
  logic [BITS_PER_CYCLE-1:0] cb;
  logic [5:0]  pa;
  logic [5:0]  pb;
  logic        last;
  logic        single;
  logic        a_zero;

  always_comb begin
    sh = 32'(k) * BITS_PER_CYCLE;
    ca = BITS_PER_CYCLE'(a_lat >> sh);
    cb = BITS_PER_CYCLE'(b_lat >> sh);
    pa = '0;
    pb = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pa = pa + 6'(ca[i]);
      pb = pb + 6'(cb[i]);
    end
    diff_nxt = diff + 7'(pa) - 7'(pb);
  end

`ifdef CMP_EARLY_EXIT_EN
  logic rest_zero;
  // nothing left to count above this chunk
  assign rest_zero =
    (((a_lat | b_lat) >> (sh + BITS_PER_CYCLE)) == 32'd0);
  assign last = (k == KLAST) | rest_zero;
`else
  assign last = (k == KLAST);
`endif

  always_comb begin
    a_zero = (a == 32'd0);
    single = 1'b0;
    case (cmp_op)
      OP_BEQ:  single = (a == b);
      OP_BGEZ: single = ~a[31];
      OP_BGTZ: single = ~a[31] & ~a_zero;
      OP_BLEZ: single = a[31] | a_zero;
      OP_BLTZ: single = a[31];
      OP_BNE:  single = (a != b);
      default: single = 1'b0;
    endcase
  end

  assign stall = (state == COUNT) |
                 ((state == IDLE) & start &
                  (cmp_op == OP_NUMEQ) & ~flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
      diff   <= '0;
      k      <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              a_lat <= a;
              b_lat <= b;
              busy  <= 1'b1;
              if (cmp_op == OP_NUMEQ) begin
                diff  <= '0;
                k     <= '0;
                state <= COUNT;
              end else begin
                result <= single;
                done   <= 1'b1;
                state  <= RESP;
              end
            end
          end
          COUNT: begin
            diff <= diff_nxt;
            k    <= k + 6'd1;
            if (last) begin
              result <= (diff_nxt == 7'd0);
              done   <= 1'b1;
              state  <= RESP;
            end
          end
          RESP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: vector table, hand sequences and random
// requests against a popcount/signed-compare model.
module tb_cmp_seq;

  localparam int BPC = 8;
  localparam int NCH = 32 / BPC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  cmp_op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        stall;
  logic        done;
  logic        result;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  cmp_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cmp_op(cmp_op),
    .a(a),
    .b(b),
    .flush(flush),
    .busy(busy),
    .stall(stall),
    .done(done),
    .result(result)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        res;
    int          lat;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic logic ref_res(logic [3:0] op,
                                   logic [31:0] x,
                                   logic [31:0] y);
    case (op)
      4'd0: return x == y;
      4'd1: return $signed(x) >= 0;
      4'd2: return $signed(x) > 0;
      4'd3: return $signed(x) <= 0;
      4'd4: return $signed(x) < 0;
      4'd5: return x != y;
      4'd6: return $countones(x) == $countones(y);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_lat(logic [3:0] op,
                                 logic [31:0] x,
                                 logic [31:0] y);
    if (op != 4'd6) return 1;
`ifdef CMP_EARLY_EXIT_EN
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 32; i++)
        if (x[i] | y[i]) hi = i / BPC;
      return hi + 2;
    end
`else
    return NCH + 1;
`endif
  endfunction

  // n = edges from the accepting edge (inclusive)
  // until done is seen; stall counted per cycle
  task automatic do_req(input string nm,
                        input logic [3:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic er,
                        input int el);
    int n;
    int sc;
    sc = 0;
    cmp_op = op;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    sc += int'(stall);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cmp_op = 4'($urandom);
    n = 1;
    while (!done && n < 64) begin
      @(negedge clk);
      sc += int'(stall);
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, n, el);
    chk({nm, " result"}, 32'(result), 32'(er));
    chk({nm, " stall cycles"}, sc,
        (op == 4'd6) ? el : 0);
    @(posedge clk);
    #1;
    chk({nm, " done/busy after"},
        {30'd0, done, busy}, 32'd0);
  endtask

  vec_t tbl[14];

  initial begin
    int dn;
    int first;
    logic [3:0] op;
    logic [31:0] x;
    logic [31:0] y;

    tbl[0]  = '{4'd0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1};
    tbl[1]  = '{4'd4, 32'h8000_0000, 32'h0, 1'b1, 1};
    tbl[2]  = '{4'd2, 32'h8000_0000, 32'h0, 1'b0, 1};
    tbl[3]  = '{4'd6, 32'h0000_00FF, 32'hF000_000F, 1'b1, 5};
    tbl[4]  = '{4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 5};
    tbl[5]  = '{4'd9, 32'h0, 32'h0, 1'b0, 1};
`ifdef CMP_EARLY_EXIT_EN
    tbl[6]  = '{4'd6, 32'h0000_000F, 32'h0000_00F0, 1'b1, 2};
`else
    tbl[6]  = '{4'd6, 32'h0000_000F, 32'h0000_00F0, 1'b1, 5};
`endif
    tbl[7]  = '{4'd1, 32'h0, 32'h5, 1'b1, 1};
    tbl[8]  = '{4'd3, 32'h0, 32'h0, 1'b1, 1};
    tbl[9]  = '{4'd5, 32'h1, 32'h2, 1'b1, 1};
    tbl[10] = '{4'd2, 32'h1, 32'h0, 1'b1, 1};
    tbl[11] = '{4'd4, 32'h7FFF_FFFF, 32'h0, 1'b0, 1};
    tbl[12] = '{4'd0, 32'h1, 32'h2, 1'b0, 1};
    tbl[13] = '{4'd15, 32'hFFFF_FFFF, 32'h0, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++)
      do_req($sformatf("vec%0d", i), tbl[i].op,
             tbl[i].x, tbl[i].y, tbl[i].res, tbl[i].lat);

    // flush during COUNT with result held at 1
    do_req("pre flush", 4'd3, 32'h0, 32'h0, 1'b1, 1);
    cmp_op = 4'd6;
    a = 32'hF000_0000;
    b = 32'h1000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b1;
    chk("flush busy before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush idle", 32'(busy), 32'd0);
    chk("flush stall low", 32'(stall), 32'd0);
    dn = int'(done);
    repeat (8) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    chk("flush no done", dn, 0);
    chk("flush result held", 32'(result), 32'd1);

    // flush and start in the same idle cycle
    cmp_op = 4'd6;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush+start stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush+start dropped", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // start while busy is ignored
    cmp_op = 4'd6;
    a = 32'h0000_00FF;
    b = 32'hF000_000F;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dn = 0;
    first = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        dn++;
        if (first == 0) first = c;
      end
      start = (c == 2);
      if (c == 2) begin
        cmp_op = 4'd0;
        a = 32'h1;
        b = 32'h2;
      end
    end
    chk("busy ignore done count", dn, 1);
    chk("busy ignore done cycle", first, 5);
    chk("busy ignore result", 32'(result), 32'd1);
    do_req("accept T+6", 4'd2, 32'h8000_0000,
           32'h0, 1'b0, 1);

    // reset in the middle of a bnumeq
    do_req("pre reset", 4'd3, 32'h0, 32'h0, 1'b1, 1);
    cmp_op = 4'd6;
    a = 32'hFFFF_0000;
    b = 32'h1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset result", 32'(result), 32'd0);
    dn = int'(done);
    repeat (6) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    chk("mid reset no done", dn, 0);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'd6;
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0)
        y = {x[15:0], x[31:16]};
      else
        y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) y = x;
      do_req($sformatf("rand%0d", i), op, x, y,
             ref_res(op, x, y), ref_lat(op, x, y));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
- Sequencer for the branch-compare datapath in the decode stage.
- Accepts one compare request at a time: the operation code plus two 32-bit operands.
- Single-cycle ops (beq/bne/sign tests) resolve in one registered cycle. bnumeq (popcount-equal) is resolved iteratively, BITS_PER_CYCLE bits per cycle, so no full 32-bit popcount tree is needed.
- Drives a stall to the pipeline hazard unit while a multi-cycle compare is in flight, and returns a registered branch-taken result with a done pulse.

Parameters:
- BITS_PER_CYCLE, 8, operand bits counted per COUNT cycle; legal values 1, 2, 4, 8, 16, 32.
- NCHUNK, 32/BITS_PER_CYCLE, derived localparam; number of COUNT cycles without early exit.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request valid; accepted only when busy=0
- cmp_op  input  4  0=beq 1=bgez 2=bgtz 3=blez 4=bltz 5=bne 6=bnumeq; 7-15 invalid
- a  input  32  operand A (rs)
- b  input  32  operand B (rt); ignored for ops 1-4
- flush  input  1  abort in-flight compare, synchronous
- busy  output  1  registered; 1 when state != IDLE
- stall  output  1  combinational; (state==COUNT) | (state==IDLE & start & cmp_op==6 & !flush)
- done  output  1  registered one-cycle pulse; result valid
- result  output  1  registered branch-taken; holds value until next done

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high. reset=1 at a rising edge forces state=IDLE, busy=0, done=0, result=0, and clears counters. This applies mid-operation too: no done is emitted for an aborted request.
- States: IDLE, COUNT, RESP.
- IDLE, start=1, flush=0:
  - Latch cmp_op, a, b.
  - Ops 0-5 and 7-15: compute result into the staging register, go to RESP.
  - Op 6: clear diff, set chunk index k=0, go to COUNT.
- Single-cycle op semantics:
  - ops 1-4 compare a as signed two's complement against 0.
  - beq: a==b. bne: a!=b.
  - Invalid ops resolve to result 0, never X or Z.
- COUNT, each cycle:
  - diff += popcount(a_lat chunk k) - popcount(b_lat chunk k), where chunk k = bits [k*BPC+BPC-1 : k*BPC].
  - diff is 7-bit signed, range -32..+32, never overflows.
  - k increments. After chunk NCHUNK-1 go to RESP, with staged result = (final diff==0).
- RESP: done=1 for exactly one cycle, result updated the same cycle, then back to IDLE.
  - start is ignored in RESP: back-to-back requests need one idle cycle.
  - busy=1 in RESP.
- Latency, with start accepted at edge T:
  - single-cycle op: done=1 in cycle T+1.
  - bnumeq: COUNT occupies cycles T+1..T+NCHUNK, done=1 in cycle T+NCHUNK+1 (T+5 at default).
- start while busy=1: ignored, not queued; operands are not re-latched.
- flush=1 at an edge in any state: go to IDLE and suppress done; result keeps its old value.
  - flush and start in the same IDLE cycle: flush wins, request dropped.
  - flush in the RESP cycle: done for that cycle is already driven; the state still returns to IDLE.
- Operand inputs may change after acceptance; only latched copies are used.
- stall drops in the cycle the state leaves COUNT. The consuming pipeline samples result on done.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: in COUNT, if all not-yet-counted bits of both a_lat and b_lat (bits above the current chunk) are zero after adding chunk k, go directly to RESP.
  - bnumeq latency becomes (index of highest chunk containing any set bit in a|b) + 2 cycles, minimum 2.
  - Result is identical to the non-exit path.
- Undefined: COUNT always runs exactly NCHUNK cycles.

Test Plan:
- Reset and simple compares:
  - reset held 2 cycles, then idle → busy=0, done=0, result=0.
  - beq, a=b=32'h1234_5678 → done and result=1 at T+1, stall never high.
  - bltz, a=32'h8000_0000 → result=1.
  - bgtz, a=32'h8000_0000 → result=0.
- bnumeq true, default parameters: a=32'h0000_00FF, b=32'hF000_000F → stall high at T..T+4, done at T+5, result=1.
  - With CMP_EARLY_EXIT_EN defined: done at T+5 (highest chunk is 3).
  - a=32'h0000_000F, b=32'h0000_00F0 with the macro: done at T+2, result=1.
- bnumeq false: a=32'hFFFF_FFFF, b=32'hFFFF_FFFE → done at T+5, result=0.
  - Change a and b during COUNT → result is still 0.
- Flush during COUNT: bnumeq start at T, flush at T+2 → state IDLE at T+3, no done pulse, result unchanged, stall low from T+3.
- Busy and invalid-op handling:
  - start with cmp_op=0 issued at T+2 while a bnumeq is busy → ignored; exactly one done at T+5.
  - A new start at T+6 is accepted.
  - cmp_op=9 → done at T+1, result=0.
